// File: rtl/memory_controller_if.sv
// memory_controller_if: request/return signals between a traffic source and the memory model
interface memory_controller_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] wr_address;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_ret_address;
    logic              wr_ret_ack;
    logic [ADDR_W-1:0] rd_address;
    logic              rd_en;
    logic [DATA_W-1:0] rd_ret_data;
    logic [ADDR_W-1:0] rd_ret_address;
    logic              rd_ret_ack;

    modport master (
        output wr_address, wr_en, wr_data, rd_address, rd_en,
        input  wr_ret_address, wr_ret_ack, rd_ret_data, rd_ret_address, rd_ret_ack
    );

    modport slave (
        input  wr_address, wr_en, wr_data, rd_address, rd_en,
        output wr_ret_address, wr_ret_ack, rd_ret_data, rd_ret_address, rd_ret_ack
    );
endinterface

// File: rtl/memory_controller.sv
// memory_controller: fixed-latency memory model with independent write and read ports
module memory_controller #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int WR_LATENCY = 4,
    parameter int RD_LATENCY = 4
) (
    input logic                clk,
    input logic                reset,
    memory_controller_if.slave bus
);
    // Array powers up zeroed; reset deliberately leaves its contents alone.
    logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};

    // Stage 0 captures the accepted request, the last stage is the output register.
    // Idle slots hold all-zero so the outputs read 0 whenever nothing completes.
    logic [ADDR_W:0]        wp [WR_LATENCY+1];
    logic [ADDR_W+DATA_W:0] rp [RD_LATENCY+1];

    // Commit writes at the accepting edge; reads on the same edge see the old word.
    always_ff @(posedge clk) begin
        if (!reset && bus.wr_en)
            mem[bus.wr_address] <= bus.wr_data;
    end

    // Write completion pipeline: {valid, address}.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '{default: '0};
        end else begin
            wp[0] <= bus.wr_en ? {1'b1, bus.wr_address} : '0;
            for (int i = 1; i <= WR_LATENCY; i++)
                wp[i] <= wp[i-1];
        end
    end

    // Read completion pipeline: {valid, address, data sampled at acceptance}.
    always_ff @(posedge clk) begin
        if (reset) begin
            rp <= '{default: '0};
        end else begin
            rp[0] <= bus.rd_en ? {1'b1, bus.rd_address, mem[bus.rd_address]} : '0;
            for (int i = 1; i <= RD_LATENCY; i++)
                rp[i] <= rp[i-1];
        end
    end

    assign bus.wr_ret_ack     = wp[WR_LATENCY][ADDR_W];
    assign bus.wr_ret_address = wp[WR_LATENCY][ADDR_W-1:0];
    assign bus.rd_ret_ack     = rp[RD_LATENCY][ADDR_W+DATA_W];
    assign bus.rd_ret_address = rp[RD_LATENCY][ADDR_W+DATA_W-1:DATA_W];
    assign bus.rd_ret_data    = rp[RD_LATENCY][DATA_W-1:0];
endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: directed checks of the fixed-latency memory model
module tb_memory_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    memory_controller_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    memory_controller #(.ADDR_W(16), .DATA_W(16), .WR_LATENCY(4), .RD_LATENCY(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    function automatic logic [49:0] pk(logic wa, logic [15:0] waddr, logic ra, logic [15:0] raddr, logic [15:0] rdat);
        return {wa, waddr, ra, raddr, rdat};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(logic we, logic [15:0] wa, logic [15:0] wd, logic re, logic [15:0] ra);
        bus.wr_en = we;
        bus.wr_address = wa;
        bus.wr_data = wd;
        bus.rd_en = re;
        bus.rd_address = ra;
    endtask

    task automatic chk(string tag, logic [49:0] exp);
        logic [49:0] obs;
        obs = pk(bus.wr_ret_ack, bus.wr_ret_address, bus.rd_ret_ack, bus.rd_ret_address, bus.rd_ret_data);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs={wack,waddr,rack,raddr,rdata}=%h exp=%h", tag, obs, exp);
        end
    endtask

    localparam logic [49:0] IDLE = '0;

    initial begin
        // Reset held with requests present: outputs stay 0, write to 0x0005 is dropped.
        drv(1'b1, 16'h0005, 16'h9999, 1'b1, 16'h0005);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_hold", IDLE);
        end
        drv(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        tick();
        chk("reset_drop", IDLE);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_reset_idle", IDLE);
        end

        // Streaming pass 1: same-edge read of a fresh array returns 0 (also proves 0x0005 was not written).
        for (int n = 0; n < 129; n++) begin
            if (n < 125) drv(1'b1, 16'(n), 16'(n), 1'b1, 16'(n));
            else drv(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
            tick();
            chk("stream_wr_rd", n >= 4 ? pk(1'b1, 16'(n-4), 1'b1, 16'(n-4), 16'h0000) : IDLE);
        end
        // Streaming pass 2: reads return the streamed data.
        for (int n = 0; n < 129; n++) begin
            if (n < 125) drv(1'b0, 16'h0000, 16'h0000, 1'b1, 16'(n));
            else drv(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
            tick();
            chk("stream_rd", n >= 4 ? pk(1'b0, 16'h0000, 1'b1, 16'(n-4), 16'(n-4)) : IDLE);
        end

        // Single write then read of 0x0042.
        drv(1'b1, 16'h0042, 16'h1234, 1'b0, 16'h0000);
        tick();
        chk("single_e0", IDLE);
        drv(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0042);
        tick();
        chk("single_e1", IDLE);
        drv(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        tick();
        chk("single_e2", IDLE);
        tick();
        chk("single_e3", IDLE);
        tick();
        chk("single_wack", pk(1'b1, 16'h0042, 1'b0, 16'h0000, 16'h0000));
        tick();
        chk("single_rack", pk(1'b0, 16'h0000, 1'b1, 16'h0042, 16'h1234));
        tick();
        chk("single_after", IDLE);

        // Collision: read-before-write on the same edge.
        drv(1'b1, 16'h0007, 16'hAAAA, 1'b0, 16'h0000);
        tick();
        drv(1'b1, 16'h0007, 16'h5555, 1'b1, 16'h0007);
        tick();
        drv(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0007);
        tick();
        drv(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        tick();
        chk("coll_e3", IDLE);
        tick();
        chk("coll_e4", pk(1'b1, 16'h0007, 1'b0, 16'h0000, 16'h0000));
        tick();
        chk("coll_old", pk(1'b1, 16'h0007, 1'b1, 16'h0007, 16'hAAAA));
        tick();
        chk("coll_new", pk(1'b0, 16'h0000, 1'b1, 16'h0007, 16'h5555));
        tick();
        chk("coll_after", IDLE);

        // Address wrap: top word and word 0 are distinct locations.
        drv(1'b1, 16'hFFFF, 16'hBEEF, 1'b0, 16'h0000);
        tick();
        drv(1'b1, 16'h0000, 16'hCAFE, 1'b0, 16'h0000);
        tick();
        drv(1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF);
        tick();
        drv(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
        tick();
        drv(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        tick();
        chk("wrap_w_ffff", pk(1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0000));
        tick();
        chk("wrap_w_0000", pk(1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000));
        tick();
        chk("wrap_r_ffff", pk(1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'hBEEF));
        tick();
        chk("wrap_r_0000", pk(1'b0, 16'h0000, 1'b1, 16'h0000, 16'hCAFE));
        tick();
        chk("wrap_after", IDLE);

        // Reset mid-flight: first requests would complete exactly on the reset edge.
        drv(1'b1, 16'h0200, 16'h1111, 1'b1, 16'h0042);
        tick();
        drv(1'b1, 16'h0201, 16'h2222, 1'b1, 16'h0007);
        tick();
        drv(1'b1, 16'h0202, 16'h3333, 1'b1, 16'hFFFF);
        tick();
        drv(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        tick();
        chk("mid_pre_reset", IDLE);
        reset = 1'b1;
        tick();
        chk("mid_reset_edge", IDLE);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_no_ack", IDLE);
        end
        for (int n = 0; n < 7; n++) begin
            if (n < 3) drv(1'b0, 16'h0000, 16'h0000, 1'b1, 16'(16'h0200 + n));
            else drv(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
            tick();
            chk("mid_readback", n >= 4 ? pk(1'b0, 16'h0000, 1'b1, 16'(16'h0200 + n - 4), 16'(16'h1111 * (n - 3))) : IDLE);
        end
        tick();
        chk("final_idle", IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
